exotiny_uart_tx: RTL and testbench
==================================

Name: exotiny_uart_tx

Overview:
- Wishbone-slave UART transmitter on the ExoTiny register bus; the console output stage.
- CPU stores to TXDATA (offset 0x0C) are queued in a small FIFO and serialised 8N1 on uart_tx_o.
- The offset is the same one sim benches snoop for console characters. This block makes those characters leave the chip.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- DIV_RST, 16'd434, baud divisor reset value: clk cycles per bit.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active high
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  5  byte address within register window
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  acknowledge
- uart_tx_o  out  1  serial output, idle high
- irq_o  out  1  level interrupt: FIFO empty and shifter idle, gated by IE

Behaviour:
- Reset values:
  - wb_ack_o=0, wb_dat_o=0, uart_tx_o=1, irq_o=0.
  - FIFO empty (rd=wr=0), FSM IDLE, DIV=DIV_RST, IE=0, OVF=0.
  - Async assert. Mid-frame reset forces uart_tx_o=1 on the same edge and discards queued data.
- Register map (wb_adr_i[4:2]); unmapped addresses ack with read data 0:
  - 0x0C TXDATA: W pushes wb_dat_i[7:0]. R returns 0.
  - 0x10 STATUS:
    - R: {27'b0, IE, OVF, busy, full, empty}.
    - W: bit4 sets IE. Writing bit2=1 clears OVF. Other bits are ignored.
  - 0x14 DIV: R/W [15:0]; upper bits read 0.
- Handshake:
  - wb_ack_o asserts exactly 1 cycle after a cycle with cyc&stb&~ack, for 1 cycle only.
  - A held strobe therefore acks every other cycle.
  - Side effects (push, register write) occur on the acking edge, once per transaction.
  - wb_dat_o is valid with ack and zero otherwise.
- FIFO:
  - Pointers are log2(DEPTH)+1 bits. full when MSBs differ and the rest are equal; empty when all bits are equal.
  - Push to full FIFO: data dropped, OVF set (sticky).
  - Push and pop on the same edge are both performed. When full, the pop completes first in that cycle, so the push is accepted and OVF is not set.
- Baud counter:
  - 16-bit down-counter, loaded with max(DIV,1)-1 at every bit start. A bit ends when the counter reaches 0.
  - DIV=0 behaves as DIV=1: 1 clk per bit.
  - DIV is sampled only when a frame starts; a DIV write mid-frame affects the next frame.
- FSM:
  - IDLE: if !empty, pop into shifter, go to START, load counter. Otherwise hold uart_tx_o=1.
  - START: uart_tx_o=0 for one bit time, then DATA with bit index 0.
  - DATA: uart_tx_o=shift[0], LSB first. After 8 bits go to STOP (or PARITY, see below).
  - STOP: uart_tx_o=1 for one bit time, then IDLE.
  - IDLE is evaluated the cycle after STOP ends, so back-to-back frames add exactly 1 idle clock between the stop bit and the next start bit.
  - uart_tx_o is registered (driven from a flop).
- busy = (state!=IDLE). irq_o = IE & empty & ~busy, registered.

Optional Feature:
- Macro EXOTINY_UART_TX_PARITY_EN.
- Defined:
  - PARITY state between DATA and STOP drives even parity (XOR of the 8 data bits) for one bit time.
  - STATUS bit5 reads 1, advertising parity.
- Undefined: no PARITY state, 8N1 framing, STATUS bit5 reads 0.

Test Plan:
- Reset then idle 50 clk -> uart_tx_o=1 throughout; STATUS reads 0x01; DIV reads 434; irq_o=0.
- DIV=4, write TXDATA=0x41 -> line 0,1,0,0,0,0,0,1,0,1, each level 4 clk wide. Start edge ≤2 clk after ack. STATUS busy=1 during frame.
- DIV=2, burst-write "DONE" without polling -> bytes 0x44 0x4F 0x4E 0x45 decoded in order. Exactly 1 idle clk between frames. empty=1 after last pop.
- DIV=100, write 6 bytes with DEPTH=4 -> first byte in shifter, next 4 queued, 6th dropped. STATUS full=1, OVF=1. Write STATUS bit2 -> OVF=0.
- Write STATUS IE=1 with idle empty FIFO -> irq_o=1. Write TXDATA -> irq_o=0 during frame, 1 again after stop bit.
- Assert rst_i mid-DATA bit 3 -> uart_tx_o=1 without waiting for a clock edge; FIFO empty. DIV=434 after release. No further frames.
- With EXOTINY_UART_TX_PARITY_EN, DIV=3, TXDATA=0x07 -> parity bit 1 before stop; STATUS bit5=1.

Source files
------------

// File: rtl/exotiny_uart_tx_if.sv
// Wishbone register-bus bundle between the ExoTiny CPU and the UART transmitter.
interface exotiny_uart_tx_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [4:0]  adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cyc, stb, we, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/exotiny_uart_tx.sv
// Console UART transmitter: TXDATA stores go through a FIFO and leave as 8N1 frames.
// Define EXOTINY_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
//
// state  | meaning
// IDLE   | line high, pop next byte when the FIFO is non-empty
// START  | start bit (line low)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (parity builds only)
// STOP   | stop bit (line high)
module exotiny_uart_tx #(
  parameter int          DEPTH   = 4,
  parameter logic [15:0] DIV_RST = 16'd434
) (
  input  logic              clk_i,
  input  logic              rst_i,
  exotiny_uart_tx_if.slave  wb,
  output logic              uart_tx_o,
  output logic              irq_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
`ifdef EXOTINY_UART_TX_PARITY_EN
  localparam logic PAR_FLAG = 1'b1;
`else
  localparam logic PAR_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]  mem_q [DEPTH];
  logic [15:0] div_q, div_d;
  logic        ie_q, ie_d, ovf_q, ovf_d;
  logic [15:0] cnt_q, cnt_d, rld_q, rld_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d, irq_q, irq_d;

  logic        empty, full, busy, req, wr_en, push, pop, push_ok, bit_done;
  logic [2:0]  sel;
  logic [15:0] div_m1;
  logic [31:0] status;
  logic [7:0]  head;
  logic        unused_bits;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign busy     = (state_q != S_IDLE);
  assign req      = wb.cyc & wb.stb & ~ack_q;
  assign wr_en    = req & wb.we;
  assign sel      = wb.adr[4:2];
  assign push     = wr_en && (sel == 3'd3);
  assign pop      = (state_q == S_IDLE) && !empty;
  // a pop on the same edge frees a slot, so a push to a full FIFO still lands
  assign push_ok  = push && (!full || pop);
  assign bit_done = (cnt_q == 16'd0);
  assign div_m1   = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign status   = {26'b0, PAR_FLAG, ie_q, ovf_q, busy, full, empty};
  assign head     = mem_q[rd_q[AW-1:0]];
  assign unused_bits = ^{wb.dat_w[31:16], wb.adr[1:0]};

  assign wb.ack    = ack_q;
  assign wb.dat_r  = dat_q;
  assign uart_tx_o = tx_q;
  assign irq_o     = irq_q;

  always_comb begin
    ack_d = req;
    dat_d = '0;
    div_d = div_q;
    ie_d  = ie_q;
    ovf_d = ovf_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (req && !wb.we) begin
      case (sel)
        3'd4:    dat_d = status;
        3'd5:    dat_d = {16'b0, div_q};
        default: dat_d = '0;
      endcase
    end
    if (wr_en && sel == 3'd4) begin
      ie_d = wb.dat_w[4];
      if (wb.dat_w[2]) ovf_d = 1'b0;
    end
    if (wr_en && sel == 3'd5) div_d = wb.dat_w[15:0];
    if (pop) rd_d = rd_q + PTR_ONE;
    if (push_ok) wr_d = wr_q + PTR_ONE;
    else if (push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= wb.dat_w[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!empty) state_d = S_START;
      S_START:  if (bit_done) state_d = S_DATA;
      S_DATA: begin
        if (bit_done && idx_q == 3'd7) begin
`ifdef EXOTINY_UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
      S_PARITY: if (bit_done) state_d = S_STOP;
      S_STOP:   if (bit_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
      S_PARITY: tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase
    irq_d = ie_q & empty & ~busy;
  end

  // the divisor is captured once per frame so DIV writes only affect the next frame
  always_comb begin
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    if (pop) begin
      rld_d   = div_m1;
      cnt_d   = div_m1;
      shift_d = head;
      idx_d   = 3'd0;
      par_d   = ^head;
    end else if (busy) begin
      if (bit_done) begin
        cnt_d = rld_q;
        if (state_q == S_DATA) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
        end
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      div_q   <= DIV_RST;
      ie_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      rld_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      div_q   <= div_d;
      ie_q    <= ie_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      irq_q   <= irq_d;
    end
  end
endmodule

// File: tb/tb_exotiny_uart_tx.sv
// Bench for exotiny_uart_tx: directed and random frames checked against a byte-to-waveform model.
module tb_exotiny_uart_tx;
  logic clk = 1'b0;
  logic rst;
  logic uart_tx, irq;

  exotiny_uart_tx_if bus();

  exotiny_uart_tx #(.DEPTH(4), .DIV_RST(16'd434)) dut (
    .clk_i(clk), .rst_i(rst), .wb(bus), .uart_tx_o(uart_tx), .irq_o(irq)
  );

  always #5 clk = ~clk;

`ifdef EXOTINY_UART_TX_PARITY_EN
  localparam int FB = 11;
  localparam logic [31:0] PB = 32'h20;
`else
  localparam int FB = 10;
  localparam logic [31:0] PB = 32'h00;
`endif

  int n_chk = 0;
  int n_err = 0;
  bit rec_en = 1'b0;
  bit line_q[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) if (rec_en) line_q.push_back(uart_tx);

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic we, input logic [4:0] adr, input logic [31:0] d,
                         output logic [31:0] rd);
    bit got = 1'b0;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.adr = adr; bus.dat_w = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.ack === 1'b1) got = 1'b1;
    end
    rd = bus.dat_r;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    chk("ack_seen", {31'b0, got}, 32'd1);
  endtask

  task automatic wb_write(input logic [4:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, d, dummy);
  endtask

  task automatic wb_read(input logic [4:0] adr, output logic [31:0] rd);
    wb_xfer(1'b0, adr, 32'h0, rd);
  endtask

  function automatic int zeros_from(input int from);
    int z = 0;
    for (int i = from; i < line_q.size(); i++) if (line_q[i] == 1'b0) z++;
    return z;
  endfunction

  // Expected line: per byte a frame of FB bit-times (start, data LSB first, [parity], stop),
  // each eff clocks wide, with one idle clock between consecutive frames.
  task automatic analyze(input string tag, input int eff, output int s);
    int n, base, bad, idx, stop_end;
    logic [10:0] bits;
    logic [7:0] dec;
    s = -1;
    for (int i = 0; i < line_q.size(); i++) if (line_q[i] == 1'b0) begin s = i; break; end
    chk({tag, "_start_found"}, {31'b0, (s >= 0)}, 32'd1);
    if (s < 0) return;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      base = s + k * (FB * eff + 1);
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1 + i] = exp_q[k][i];
      if (FB == 11) bits[9] = ^exp_q[k];
      bits[FB - 1] = 1'b1;
      bad = 0;
      for (int j = 0; j < FB; j++)
        for (int t = 0; t < eff; t++) begin
          idx = base + j * eff + t;
          if (idx >= line_q.size() || line_q[idx] != bits[j]) bad++;
        end
      if (k < n - 1) begin
        idx = base + FB * eff;
        if (idx + 1 >= line_q.size() || line_q[idx] != 1'b1 || line_q[idx + 1] != 1'b0) bad++;
      end
      dec = '0;
      for (int i = 0; i < 8; i++) begin
        idx = base + (1 + i) * eff + eff / 2;
        if (idx < line_q.size()) dec[i] = line_q[idx];
      end
      chk($sformatf("%s_wave%0d", tag, k), bad, 32'd0);
      chk($sformatf("%s_byte%0d", tag, k), {24'b0, dec}, {24'b0, exp_q[k]});
    end
    stop_end = s + n * (FB * eff + 1) - 1;
    chk({tag, "_tail_len"}, {31'b0, (line_q.size() > stop_end + 2)}, 32'd1);
    chk({tag, "_tail_idle"}, zeros_from(stop_end), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int s, a, eff, nb;
    logic [15:0] dv;
    bit found;

    rst = 1'b1;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.dat_w = '0;
    tick(3);
    chk("rst_tx", {31'b0, uart_tx}, 32'd1);
    chk("rst_ack", {31'b0, bus.ack}, 32'd0);
    rst = 1'b0;

    // reset state and idle line
    line_q.delete(); rec_en = 1'b1;
    tick(50);
    rec_en = 1'b0;
    chk("idle_len", line_q.size(), 32'd50);
    chk("idle_line", zeros_from(0), 32'd0);
    chk("idle_irq", {31'b0, irq}, 32'd0);
    chk("idle_dat", bus.dat_r, 32'd0);
    wb_read(5'h10, r);
    chk("rst_status", r, 32'h01 | PB);
    wb_read(5'h14, r);
    chk("rst_div", r, 32'd434);
    tick(1);
    chk("ack_one_cycle", {31'b0, bus.ack}, 32'd0);
    chk("dat_zero_noack", bus.dat_r, 32'd0);
    wb_read(5'h0C, r);
    chk("txdata_reads0", r, 32'd0);
    wb_read(5'h00, r);
    chk("unmapped_reads0", r, 32'd0);

    // single frame at DIV=4
    wb_write(5'h14, 32'd4);
    line_q.delete(); exp_q = '{8'h41};
    rec_en = 1'b1;
    wb_write(5'h0C, 32'h41);
    a = line_q.size();
    tick(6);
    wb_read(5'h10, r);
    chk("busy_mid_frame", {31'b0, r[2]}, 32'd1);
    tick(60);
    rec_en = 1'b0;
    analyze("A41", 4, s);
    chk("start_latency", {31'b0, (s >= a && s - a <= 2)}, 32'd1);

    // burst "DONE" at DIV=2
    wb_write(5'h14, 32'd2);
    line_q.delete(); exp_q = '{8'h44, 8'h4F, 8'h4E, 8'h45};
    rec_en = 1'b1;
    foreach (exp_q[i]) wb_write(5'h0C, {24'b0, exp_q[i]});
    tick(4 * (FB * 2 + 1) + 20);
    rec_en = 1'b0;
    analyze("DONE", 2, s);
    wb_read(5'h10, r);
    chk("done_status", r, 32'h01 | PB);

    // overflow at DIV=100
    wb_write(5'h14, 32'd100);
    line_q.delete(); exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    rec_en = 1'b1;
    for (int i = 0; i < 6; i++) wb_write(5'h0C, 32'h31 + i);
    wb_read(5'h10, r);
    chk("ovf_status", r, 32'h0E | PB);
    wb_write(5'h10, 32'h04);
    wb_read(5'h10, r);
    chk("ovf_cleared", r, 32'h06 | PB);
    tick(5 * (FB * 100 + 1) + 30);
    rec_en = 1'b0;
    analyze("OVF", 100, s);
    wb_read(5'h10, r);
    chk("ovf_drained", r, 32'h01 | PB);

    // interrupt
    wb_write(5'h14, 32'd2);
    wb_write(5'h10, 32'h10);
    tick(2);
    chk("irq_set", {31'b0, irq}, 32'd1);
    wb_write(5'h0C, 32'h55);
    tick(3);
    chk("irq_drop", {31'b0, irq}, 32'd0);
    tick(8);
    chk("irq_mid", {31'b0, irq}, 32'd0);
    tick(FB * 2);
    chk("irq_back", {31'b0, irq}, 32'd1);
    wb_read(5'h10, r);
    chk("irq_status", r, 32'h11 | PB);

    // parity-relevant directed byte
    wb_write(5'h14, 32'd3);
    line_q.delete(); exp_q = '{8'h07};
    rec_en = 1'b1;
    wb_write(5'h0C, 32'h07);
    tick(FB * 3 + 20);
    rec_en = 1'b0;
    analyze("P07", 3, s);

    // random frames, including DIV=0
    for (int it = 0; it < 4; it++) begin
      dv = 16'($urandom_range(0, 5));
      eff = (dv == 16'd0) ? 1 : int'(dv);
      nb = $urandom_range(1, 4);
      wb_write(5'h14, {16'b0, dv});
      wb_read(5'h14, r);
      chk($sformatf("rnd%0d_div", it), r, {16'b0, dv});
      line_q.delete(); exp_q.delete();
      for (int i = 0; i < nb; i++) exp_q.push_back(8'($urandom_range(0, 255)));
      rec_en = 1'b1;
      foreach (exp_q[i]) wb_write(5'h0C, {24'b0, exp_q[i]});
      tick(nb * (FB * eff + 1) + 20);
      rec_en = 1'b0;
      analyze($sformatf("rnd%0d", it), eff, s);
    end

    // reset in the middle of data bit 3
    wb_write(5'h10, 32'h00);
    wb_write(5'h14, 32'd8);
    wb_write(5'h0C, 32'hA5);
    wb_write(5'h0C, 32'h33);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick(1);
      if (uart_tx === 1'b0) found = 1'b1;
    end
    chk("rst_frame_started", {31'b0, found}, 32'd1);
    tick(36);
    chk("rst_bit3_low", {31'b0, uart_tx}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_tx", {31'b0, uart_tx}, 32'd1);
    tick(2);
    rst = 1'b0;
    wb_read(5'h10, r);
    chk("rst_fifo_empty", r, 32'h01 | PB);
    wb_read(5'h14, r);
    chk("rst_div_back", r, 32'd434);
    line_q.delete(); rec_en = 1'b1;
    tick(200);
    rec_en = 1'b0;
    chk("rst_no_frames", zeros_from(0), 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
